// File: rtl/pc_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_mon_pkg
//  Purpose  : Shared types and constants for the fetch-PC flow monitor.
//  Revision : 1.0
// ============================================================================
package pc_mon_pkg;

    typedef enum logic [1:0] {
        KIND_SEQ  = 2'd0,
        KIND_JUMP = 2'd1,
        KIND_ANOM = 2'd2
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned PC_STEP = 4;

endpackage
`default_nettype wire

// File: rtl/pc_trace_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trace_buf
//  Purpose  : Circular trace of non-sequential PC transitions, read oldest-first.
//  Revision : 1.0
// ============================================================================
module pc_trace_buf
    import pc_mon_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           push,
    input  logic [XLEN-1:0]                push_from,
    input  logic [XLEN-1:0]                push_to,
    input  logic [1:0]                     push_kind,
    input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
    output logic [$clog2(TRACE_DEPTH):0]   cnt,
    output logic [XLEN-1:0]                rd_from,
    output logic [XLEN-1:0]                rd_to,
    output logic [1:0]                     rd_kind
);

    localparam int IDX_W = $clog2(TRACE_DEPTH);
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(TRACE_DEPTH);

    logic [XLEN-1:0]  from_mem [TRACE_DEPTH];
    logic [XLEN-1:0]  to_mem   [TRACE_DEPTH];
    logic [1:0]       kind_mem [TRACE_DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic             rd_ok;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (cnt != FULL) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            from_mem[wr_ptr] <= push_from;
            to_mem[wr_ptr]   <= push_to;
            kind_mem[wr_ptr] <= push_kind;
        end
    end

    // Oldest entry sits cnt slots behind the write pointer; when full the
    // low bits of cnt are zero, so the oldest is the slot about to be overwritten.
    assign rd_ptr = wr_ptr - cnt[IDX_W-1:0] + rd_idx;
    assign rd_ok  = ({1'b0, rd_idx} < cnt);

    assign rd_from = rd_ok ? from_mem[rd_ptr] : '0;
    assign rd_to   = rd_ok ? to_mem[rd_ptr]   : '0;
    assign rd_kind = rd_ok ? kind_mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/pc_flow_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : pc_flow_monitor
//  Purpose  : Classifies fetch-PC transitions, counts them and renders a verdict.
//  Revision : 1.0
// ============================================================================
module pc_flow_monitor
    import pc_mon_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MAX_SAMPLES = 30,
    parameter int TRACE_DEPTH = 8,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_i,
    input  logic                           pc_valid_i,
    input  logic [XLEN-1:0]                pc_i,
    input  logic                           redirect_i,
    input  logic [XLEN-1:0]                watch_pc_i,
    output logic [1:0]                     state_o,
    output logic                           done_o,
    output logic                           pass_o,
    output logic [CNT_W-1:0]               sample_cnt_o,
    output logic [CNT_W-1:0]               seq_cnt_o,
    output logic [CNT_W-1:0]               jump_cnt_o,
    output logic [CNT_W-1:0]               err_cnt_o,
    output logic [CNT_W-1:0]               watch_hits_o,
    output logic                           first_err_valid_o,
    output logic [XLEN-1:0]                first_err_prev_o,
    output logic [XLEN-1:0]                first_err_pc_o,
    output logic [$clog2(TRACE_DEPTH):0]   trace_cnt_o,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
    output logic [XLEN-1:0]                trace_from_o,
    output logic [XLEN-1:0]                trace_to_o,
    output logic [1:0]                     trace_kind_o
);

    state_e          state, state_nxt;
    kind_e           kind;
    logic [XLEN-1:0] last_pc, nxt_pc;
    logic            restart, accept, classify, push, done_hit;
    logic [CNT_W-1:0] sample_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign restart    = !rst_n || clear_i;
    assign accept     = pc_valid_i && (state != ST_DONE) && !restart;
    assign classify   = accept && (state == ST_RUN);
    assign push       = classify && (kind != KIND_SEQ);
    assign nxt_pc     = last_pc + XLEN'(PC_STEP);
    assign sample_inc = sat_inc(sample_cnt_o);
    assign done_hit   = (sample_inc == CNT_W'(MAX_SAMPLES));

    // A redirect always wins, even when its target happens to be last_pc+4.
    always_comb begin
        kind = KIND_ANOM;
        if (redirect_i) begin
            kind = KIND_JUMP;
        end else if (pc_i == nxt_pc) begin
            kind = KIND_SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = done_hit ? ST_DONE : ST_RUN;
            ST_RUN:  if (accept && done_hit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            last_pc           <= '0;
            sample_cnt_o      <= '0;
            seq_cnt_o         <= '0;
            jump_cnt_o        <= '0;
            err_cnt_o         <= '0;
            watch_hits_o      <= '0;
            first_err_valid_o <= 1'b0;
            first_err_prev_o  <= '0;
            first_err_pc_o    <= '0;
        end else if (accept) begin
            last_pc      <= pc_i;
            sample_cnt_o <= sample_inc;
            if (pc_i == watch_pc_i) begin
                watch_hits_o <= sat_inc(watch_hits_o);
            end
            if (classify) begin
                case (kind)
                    KIND_SEQ:  seq_cnt_o  <= sat_inc(seq_cnt_o);
                    KIND_JUMP: jump_cnt_o <= sat_inc(jump_cnt_o);
                    default:   err_cnt_o  <= sat_inc(err_cnt_o);
                endcase
                if (kind == KIND_ANOM && !first_err_valid_o) begin
                    first_err_valid_o <= 1'b1;
                    first_err_prev_o  <= last_pc;
                    first_err_pc_o    <= pc_i;
                end
            end
        end
    end

    assign state_o = state;
    assign done_o  = (state == ST_DONE);
    assign pass_o  = done_o && (err_cnt_o == '0);

    pc_trace_buf #(
        .XLEN        (XLEN),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_i),
        .push      (push),
        .push_from (last_pc),
        .push_to   (pc_i),
        .push_kind (kind),
        .rd_idx    (trace_idx_i),
        .cnt       (trace_cnt_o),
        .rd_from   (trace_from_o),
        .rd_to     (trace_to_o),
        .rd_kind   (trace_kind_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pc_flow_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_flow_monitor
//  Purpose  : Directed self-checking bench for pc_flow_monitor.
//  Revision : 1.0
// ============================================================================
module tb_pc_flow_monitor;

    logic        clk = 1'b0;
    logic        rst_n, clear_i, pc_valid_i, redirect_i;
    logic [31:0] pc_i, watch_pc_i;
    logic [1:0]  state_o, trace_kind_o;
    logic        done_o, pass_o, first_err_valid_o;
    logic [15:0] sample_cnt_o, seq_cnt_o, jump_cnt_o, err_cnt_o, watch_hits_o;
    logic [31:0] first_err_prev_o, first_err_pc_o, trace_from_o, trace_to_o;
    logic [3:0]  trace_cnt_o;
    logic [2:0]  trace_idx_i;

    int checks = 0;
    int errors = 0;

    pc_flow_monitor dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clear_i           (clear_i),
        .pc_valid_i        (pc_valid_i),
        .pc_i              (pc_i),
        .redirect_i        (redirect_i),
        .watch_pc_i        (watch_pc_i),
        .state_o           (state_o),
        .done_o            (done_o),
        .pass_o            (pass_o),
        .sample_cnt_o      (sample_cnt_o),
        .seq_cnt_o         (seq_cnt_o),
        .jump_cnt_o        (jump_cnt_o),
        .err_cnt_o         (err_cnt_o),
        .watch_hits_o      (watch_hits_o),
        .first_err_valid_o (first_err_valid_o),
        .first_err_prev_o  (first_err_prev_o),
        .first_err_pc_o    (first_err_pc_o),
        .trace_cnt_o       (trace_cnt_o),
        .trace_idx_i       (trace_idx_i),
        .trace_from_o      (trace_from_o),
        .trace_to_o        (trace_to_o),
        .trace_kind_o      (trace_kind_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One accepted sample per call; called and returns at a falling edge.
    task automatic drive(input logic [31:0] pc, input logic redir);
        pc_valid_i = 1'b1;
        pc_i       = pc;
        redirect_i = redir;
        @(negedge clk);
        pc_valid_i = 1'b0;
        redirect_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    task automatic read_trace(input logic [2:0] idx);
        trace_idx_i = idx;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        clear_i     = 1'b0;
        pc_valid_i  = 1'b0;
        redirect_i  = 1'b0;
        pc_i        = '0;
        watch_pc_i  = 32'h38;
        trace_idx_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("reset_state",      32'(state_o), 32'd0);
        check("reset_samples",    32'(sample_cnt_o), 32'd0);
        check("reset_trace_cnt",  32'(trace_cnt_o), 32'd0);
        check("reset_first_err",  32'(first_err_valid_o), 32'd0);

        // Straight-line run 0x00..0x74 with a 5-cycle stall after 0x1C
        for (int i = 0; i < 30; i++) begin
            drive(32'(i * 4), 1'b0);
            if (i == 0) begin
                check("first_to_run",   32'(state_o), 32'd1);
                check("first_sample",   32'(sample_cnt_o), 32'd1);
                check("first_no_class", 32'(seq_cnt_o), 32'd0);
            end
            if (i == 7) begin
                pc_i       = 32'hDEAD_0000;
                redirect_i = 1'b1;
                repeat (5) @(negedge clk);
                redirect_i = 1'b0;
                check("stall_samples", 32'(sample_cnt_o), 32'd8);
                check("stall_jumps",   32'(jump_cnt_o), 32'd0);
            end
        end
        check("seq_done",       32'(done_o), 32'd1);
        check("seq_state",      32'(state_o), 32'd2);
        check("seq_cnt",        32'(seq_cnt_o), 32'd29);
        check("seq_err",        32'(err_cnt_o), 32'd0);
        check("seq_pass",       32'(pass_o), 32'd1);
        check("seq_trace_cnt",  32'(trace_cnt_o), 32'd0);
        check("seq_watch_hits", 32'(watch_hits_o), 32'd1);
        check("seq_no_anom",    32'(first_err_valid_o), 32'd0);
        drive(32'h78, 1'b0);
        check("done_ignores", 32'(sample_cnt_o), 32'd30);

        // clear_i with a simultaneous valid sample
        pc_valid_i = 1'b1;
        pc_i       = 32'h38;
        do_clear();
        pc_valid_i = 1'b0;
        check("clear_state",   32'(state_o), 32'd0);
        check("clear_samples", 32'(sample_cnt_o), 32'd0);
        check("clear_seq",     32'(seq_cnt_o), 32'd0);
        check("clear_watch",   32'(watch_hits_o), 32'd0);

        // Redirect case
        for (int i = 0; i < 5; i++) drive(32'(i * 4), 1'b0);
        drive(32'h20, 1'b1);
        drive(32'h24, 1'b0);
        check("jmp_cnt",       32'(jump_cnt_o), 32'd1);
        check("jmp_seq",       32'(seq_cnt_o), 32'd5);
        check("jmp_err",       32'(err_cnt_o), 32'd0);
        check("jmp_trace_cnt", 32'(trace_cnt_o), 32'd1);
        read_trace(3'd0);
        check("jmp_tr0_from", trace_from_o, 32'h10);
        check("jmp_tr0_to",   trace_to_o, 32'h20);
        check("jmp_tr0_kind", 32'(trace_kind_o), 32'd1);
        read_trace(3'd1);
        check("jmp_tr1_empty_from", trace_from_o, 32'h0);
        check("jmp_tr1_empty_to",   trace_to_o, 32'h0);
        drive(32'h28, 1'b1);
        check("jmp_to_nxt_is_jump", 32'(jump_cnt_o), 32'd2);
        read_trace(3'd1);
        check("jmp_tr1_from", trace_from_o, 32'h24);
        check("jmp_tr1_to",   trace_to_o, 32'h28);

        // Reset asserted mid-RUN together with a valid sample
        pc_valid_i = 1'b1;
        pc_i       = 32'h2C;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        pc_valid_i = 1'b0;
        check("rst_mid_state",   32'(state_o), 32'd0);
        check("rst_mid_samples", 32'(sample_cnt_o), 32'd0);
        check("rst_mid_jumps",   32'(jump_cnt_o), 32'd0);
        check("rst_mid_trace",   32'(trace_cnt_o), 32'd0);

        // Anomaly case
        drive(32'h00, 1'b0);
        drive(32'h04, 1'b0);
        drive(32'h14, 1'b0);
        check("anom_err",   32'(err_cnt_o), 32'd1);
        check("anom_valid", 32'(first_err_valid_o), 32'd1);
        check("anom_prev",  first_err_prev_o, 32'h04);
        check("anom_pc",    first_err_pc_o, 32'h14);
        for (int a = 32'h18; a <= 32'h40; a += 4) drive(32'(a), 1'b0);
        drive(32'h48, 1'b0);
        drive(32'h48, 1'b0);
        check("anom_err3",      32'(err_cnt_o), 32'd3);
        check("anom_keep_prev", first_err_prev_o, 32'h04);
        check("anom_keep_pc",   first_err_pc_o, 32'h14);
        read_trace(3'd2);
        check("anom_tr2_kind",  32'(trace_kind_o), 32'd2);
        check("anom_tr2_from",  trace_from_o, 32'h48);
        for (int i = 0; i < 14; i++) drive(32'(32'h4C + i * 4), 1'b0);
        check("anom_done",  32'(done_o), 32'd1);
        check("anom_pass",  32'(pass_o), 32'd0);
        check("anom_seq",   32'(seq_cnt_o), 32'd26);
        check("anom_trace", 32'(trace_cnt_o), 32'd3);

        // Trace overflow: ten redirects into an 8-deep buffer
        do_clear();
        drive(32'h1000, 1'b0);
        for (int k = 1; k <= 10; k++) drive(32'(32'h2000 + k * 32'h100), 1'b1);
        check("ovf_trace_cnt", 32'(trace_cnt_o), 32'd8);
        check("ovf_jumps",     32'(jump_cnt_o), 32'd10);
        read_trace(3'd0);
        check("ovf_tr0_from", trace_from_o, 32'h2200);
        check("ovf_tr0_to",   trace_to_o, 32'h2300);
        check("ovf_tr0_kind", 32'(trace_kind_o), 32'd1);
        read_trace(3'd7);
        check("ovf_tr7_from", trace_from_o, 32'h2900);
        check("ovf_tr7_to",   trace_to_o, 32'h2A00);

        // Address wrap counts as sequential
        do_clear();
        drive(32'hFFFF_FFF8, 1'b0);
        drive(32'hFFFF_FFFC, 1'b0);
        drive(32'h0000_0000, 1'b0);
        drive(32'h0000_0004, 1'b0);
        check("wrap_seq", 32'(seq_cnt_o), 32'd3);
        check("wrap_err", 32'(err_cnt_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
